// File: rtl/mux_sel_ctrl_pkg.sv
// Shared definitions for the button-driven mux select controller.
// Holds the debounce FSM state encoding and default parameter values.
// Imported by the interface and the controller top.
package mux_sel_ctrl_pkg;

    // Encodings are fixed so debug taps and other button blocks agree on them.
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PRESS_WAIT = 2'd1,
        S_PRESSED    = 2'd2,
        S_REL_WAIT   = 2'd3
    } state_t;

    localparam int DEB_CYCLES_DEFAULT = 4;
    localparam int CNT_W_DEFAULT      = 8;

    // Any state other than idle means a press or release is in flight.
    function automatic logic is_busy(input state_t s);
        return (s != S_IDLE);
    endfunction

endpackage

// File: rtl/mux_sel_ctrl_if.sv
// Purpose: bundles the raw button input and the select/debug outputs of mux_sel_ctrl.
// Latency: none (pure wiring).
// Backpressure: none; all signals are free-running levels or single-cycle strobes.
// Ports: btn_in (raw button), sel (mux select), toggle_pulse (1-cycle strobe),
//        press_cnt (accepted presses, wrapping), busy (FSM not idle).
interface mux_sel_ctrl_if
    import mux_sel_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic             btn_in;
    logic             sel;
    logic             toggle_pulse;
    logic [CNT_W-1:0] press_cnt;
    logic             busy;

    // master: the controller that produces sel and the debug outputs.
    modport master (
        input  btn_in,
        output sel,
        output toggle_pulse,
        output press_cnt,
        output busy
    );

    // slave: the board side that supplies the button and consumes sel.
    modport slave (
        output btn_in,
        input  sel,
        input  toggle_pulse,
        input  press_cnt,
        input  busy
    );
endinterface

// File: rtl/mux_sel_ctrl_sync_2ff.sv
// Purpose: two-flop synchronizer for a single asynchronous input; reset value 0.
// Latency: 2 clk edges from d to q.
// Backpressure: none; samples d every cycle.
// Ports: clk, rst (sync, active-high), d (async input), q (synchronized output).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/mux_sel_ctrl.sv
// Purpose: synchronizes and debounces a push-button; each accepted press flips sel.
// Latency: sel/toggle_pulse update DEB_CYCLES+3 edges after btn_in first samples high.
// Backpressure: none; button events are consumed unconditionally every cycle.
// Ports: clk, rst (sync, active-high), bus (master modport: btn_in in;
//        sel, toggle_pulse, press_cnt, busy out -- all registered).
module mux_sel_ctrl
    import mux_sel_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    mux_sel_ctrl_if.master bus
);
    localparam int             DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic btn_s;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btn_in),
        .q   (btn_s)
    );

    state_t           state_q,        state_d;
    logic [DEB_W-1:0] deb_cnt_q,      deb_cnt_d;
    logic             sel_q,          sel_d;
    logic             toggle_pulse_q, toggle_pulse_d;
    logic [CNT_W-1:0] press_cnt_q,    press_cnt_d;
    logic             busy_q,         busy_d;

    always_comb begin
        state_d        = state_q;
        deb_cnt_d      = deb_cnt_q;
        sel_d          = sel_q;
        toggle_pulse_d = 1'b0;
        press_cnt_d    = press_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (btn_s) begin
                    state_d   = S_PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = S_IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d        = S_PRESSED;
                    sel_d          = ~sel_q;
                    toggle_pulse_d = 1'b1;
                    press_cnt_d    = press_cnt_q + CNT_W'(1);
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            S_PRESSED: begin
                // Holding the button parks here; only a release moves on.
                if (!btn_s) begin
                    state_d   = S_REL_WAIT;
                    deb_cnt_d = '0;
                end
            end
            S_REL_WAIT: begin
                if (btn_s) begin
                    state_d = S_PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered from the next state so busy tracks the state register exactly.
        busy_d = is_busy(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            deb_cnt_q      <= '0;
            sel_q          <= 1'b0;
            toggle_pulse_q <= 1'b0;
            press_cnt_q    <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            deb_cnt_q      <= deb_cnt_d;
            sel_q          <= sel_d;
            toggle_pulse_q <= toggle_pulse_d;
            press_cnt_q    <= press_cnt_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.sel          = sel_q;
    assign bus.toggle_pulse = toggle_pulse_q;
    assign bus.press_cnt    = press_cnt_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Purpose: self-checking bench for mux_sel_ctrl with DEB_CYCLES=4, CNT_W=8.
// Latency: expects each accepted press to toggle 7 edges after btn_in first samples high.
// Backpressure: n/a; stimulus drives btn_in/rst on falling edges, outputs sampled on falling edges.
module tb_mux_sel_ctrl;

    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    typedef struct {
        int         cyc;
        logic       sel;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;

    exp_t       sb[$];
    logic       exp_sel;
    logic [7:0] exp_cnt;

    mux_sel_ctrl_if #(.CNT_W(8)) bus ();

    mux_sel_ctrl #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Called on the falling edge where btn_in first goes high for a press that must be accepted.
    task automatic push_press();
        exp_t e;
        exp_sel = ~exp_sel;
        exp_cnt = exp_cnt + 8'd1;
        e.cyc   = cyc + LAT;
        e.sel   = exp_sel;
        e.cnt   = exp_cnt;
        sb.push_back(e);
    endtask

    // Toggle monitor: every pulse must match the oldest expected press in cycle, sel and count.
    always @(negedge clk) begin
        exp_t e;
        if (bus.toggle_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_toggle: pulse at cycle %0d with no press expected", cyc);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (cyc !== e.cyc) $display("FAIL toggle_time: pulse at cycle %0d, required %0d", cyc, e.cyc);
                else n_pass++;
                n_checks++;
                if (bus.sel !== e.sel) $display("FAIL toggle_sel: sel=%b, required %b", bus.sel, e.sel);
                else n_pass++;
                n_checks++;
                if (bus.press_cnt !== e.cnt) $display("FAIL toggle_cnt: press_cnt=%0d, required %0d", bus.press_cnt, e.cnt);
                else n_pass++;
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_checks++;
            $display("FAIL missing_toggle: no pulse by cycle %0d, required at %0d", cyc, e.cyc);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_sel = 1'b0;
        exp_cnt = 8'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_in = 1'b1;
        exp_sel = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.sel !== 1'b0) $display("FAIL reset_sel: sel=%b, required 0", bus.sel);
            else n_pass++;
            n_checks++;
            if (bus.press_cnt !== 8'd0) $display("FAIL reset_cnt: press_cnt=%0d, required 0", bus.press_cnt);
            else n_pass++;
            n_checks++;
            if (bus.busy !== 1'b0) $display("FAIL reset_busy: busy=%b, required 0", bus.busy);
            else n_pass++;
            n_checks++;
            if (bus.toggle_pulse !== 1'b0) $display("FAIL reset_pulse: toggle_pulse=%b, required 0", bus.toggle_pulse);
            else n_pass++;
        end
        // Button held through reset release counts as a fresh press.
        rst = 1'b0;
        push_press();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy_e2: busy=%b, required 0", bus.busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL reset_busy_e3: busy=%b, required 1", bus.busy);
        else n_pass++;
        repeat (10) @(negedge clk);
        bus.btn_in = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_hold();
        int t0;
        do_reset();
        bus.btn_in = 1'b1;
        push_press();
        repeat (20) @(negedge clk);
        n_checks++;
        if (bus.sel !== 1'b1) $display("FAIL hold_sel: sel=%b, required 1", bus.sel);
        else n_pass++;
        n_checks++;
        if (bus.press_cnt !== 8'd1) $display("FAIL hold_cnt: press_cnt=%0d, required 1", bus.press_cnt);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL hold_busy: busy=%b, required 1", bus.busy);
        else n_pass++;
        bus.btn_in = 1'b0;
        t0 = cyc;
        repeat (LAT - 1) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL release_busy_early: busy=%b at +%0d, required 1", bus.busy, cyc - t0);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL release_busy: busy=%b at +%0d, required 0", bus.busy, cyc - t0);
        else n_pass++;
        repeat (13) @(negedge clk);
    endtask

    task automatic test_bounce();
        bus.btn_in = 1'b1; @(negedge clk);
        bus.btn_in = 1'b0; @(negedge clk);
        bus.btn_in = 1'b1; @(negedge clk);
        bus.btn_in = 1'b0; @(negedge clk);
        bus.btn_in = 1'b1;
        push_press();
        repeat (15) @(negedge clk);
        n_checks++;
        if (bus.press_cnt !== exp_cnt) $display("FAIL bounce_cnt: press_cnt=%0d, required %0d", bus.press_cnt, exp_cnt);
        else n_pass++;
        n_checks++;
        if (bus.sel !== exp_sel) $display("FAIL bounce_sel: sel=%b, required %b", bus.sel, exp_sel);
        else n_pass++;
        bus.btn_in = 1'b0;
        repeat (15) @(negedge clk);
    endtask

    // High for 3 and 4 cycles is too short to accept; 5 cycles is the shortest accepted press.
    task automatic test_glitch();
        for (int w = 3; w <= 5; w++) begin
            bus.btn_in = 1'b1;
            if (w == 5) push_press();
            repeat (w) @(negedge clk);
            bus.btn_in = 1'b0;
            repeat (15) @(negedge clk);
            n_checks++;
            if (bus.press_cnt !== exp_cnt) $display("FAIL glitch_cnt_w%0d: press_cnt=%0d, required %0d", w, bus.press_cnt, exp_cnt);
            else n_pass++;
            n_checks++;
            if (bus.busy !== 1'b0) $display("FAIL glitch_busy_w%0d: busy=%b, required 0", w, bus.busy);
            else n_pass++;
        end
    endtask

    task automatic test_release_bounce();
        bus.btn_in = 1'b1;
        push_press();
        repeat (10) @(negedge clk);
        bus.btn_in = 1'b0;
        repeat (2) @(negedge clk);
        bus.btn_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== 1'b1) $display("FAIL relbounce_busy: busy=%b at step %0d, required 1", bus.busy, i);
            else n_pass++;
        end
        n_checks++;
        if (bus.press_cnt !== exp_cnt) $display("FAIL relbounce_cnt: press_cnt=%0d, required %0d", bus.press_cnt, exp_cnt);
        else n_pass++;
        bus.btn_in = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL relbounce_idle: busy=%b, required 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            bus.btn_in = 1'b1;
            push_press();
            repeat (10) @(negedge clk);
            bus.btn_in = 1'b0;
            repeat (10) @(negedge clk);
        end
        n_checks++;
        if (bus.press_cnt !== 8'd0) $display("FAIL wrap_cnt: press_cnt=%0d, required 0", bus.press_cnt);
        else n_pass++;
        n_checks++;
        if (bus.sel !== 1'b0) $display("FAIL wrap_sel: sel=%b, required 0", bus.sel);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.btn_in = 1'b1;
        push_press();
        repeat (10) @(negedge clk);
        bus.btn_in = 1'b0;
        repeat (10) @(negedge clk);
        // New press: FSM is in S_PRESS_WAIT with deb_cnt=2 after the 5th edge.
        bus.btn_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        bus.btn_in = 1'b0;
        exp_sel = 1'b0;
        exp_cnt = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL midrst_busy: busy=%b, required 0", bus.busy);
        else n_pass++;
        n_checks++;
        if (bus.sel !== 1'b0) $display("FAIL midrst_sel: sel=%b, required 0", bus.sel);
        else n_pass++;
        n_checks++;
        if (bus.toggle_pulse !== 1'b0) $display("FAIL midrst_pulse: toggle_pulse=%b, required 0", bus.toggle_pulse);
        else n_pass++;
        n_checks++;
        if (bus.press_cnt !== 8'd0) $display("FAIL midrst_cnt: press_cnt=%0d, required 0", bus.press_cnt);
        else n_pass++;
        repeat (15) @(negedge clk);
        n_checks++;
        if (bus.sel !== 1'b0) $display("FAIL midrst_sel_late: sel=%b, required 0", bus.sel);
        else n_pass++;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        bus.btn_in = 1'b0;
        exp_sel    = 1'b0;
        exp_cnt    = 8'd0;

        test_reset();
        test_hold();
        test_bounce();
        test_glitch();
        test_release_bounce();
        test_wrap();
        test_reset_mid();

        repeat (5) @(negedge clk);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d presses outstanding, required 0", sb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
